// File: rtl/dut_addr_pkg.sv
// dut_addr_pkg: register map addresses and CTRL bit positions
package dut_addr_pkg;
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_OFFSET = 1;
  localparam int ADDR_GP     = 2;
  localparam int ADDR_STATUS = 3;
  localparam int ADDR_COUNT  = 4;
  localparam int CTRL_OFS_EN = 0;
  localparam int CTRL_SAT_EN = 1;
endpackage

// File: rtl/addr_regfile.sv
// addr_regfile: CTRL/OFFSET/GP/STATUS/COUNT storage with read, error and datapath strobes
module addr_regfile
  import dut_addr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ovf_set,
  input  logic              cnt_inc,
  output logic              ofs_en,
  output logic              sat_en,
  output logic [WIDTH-1:0]  offset,
  output logic [WIDTH-1:0]  rd_value,
  output logic              rd_valid,
  output logic              err
);
  logic [WIDTH-1:0] ctrl_q, ctrl_d, offset_q, offset_d, gp_q, gp_d, count_q, count_d;
  logic [WIDTH-1:0] rd_value_q, rd_value_d, rd_mux;
  logic             ovf_q, ovf_d, rd_valid_q, rd_valid_d, err_q, err_d, bad, wr;
  int               a;
  always_comb begin
    a          = int'(addr);
    bad        = a > ADDR_COUNT;
    wr         = req_valid & wr_rd & ~bad;
    rd_mux     = a == ADDR_CTRL   ? ctrl_q   :
                 a == ADDR_OFFSET ? offset_q :
                 a == ADDR_GP     ? gp_q     :
                 a == ADDR_STATUS ? WIDTH'(ovf_q) :
                 a == ADDR_COUNT  ? count_q  : '0;
    ctrl_d     = (wr && a == ADDR_CTRL)   ? wdata : ctrl_q;
    offset_d   = (wr && a == ADDR_OFFSET) ? wdata : offset_q;
    gp_d       = (wr && a == ADDR_GP)     ? wdata : gp_q;
    // a new overflow beats a simultaneous write-1-to-clear
    ovf_d      = ovf_set | (ovf_q & !(wr && a == ADDR_STATUS && wdata[0]));
    count_d    = (wr && a == ADDR_COUNT) ? '0 : count_q + WIDTH'(cnt_inc);
    rd_valid_d = req_valid & ~wr_rd;
    rd_value_d = rd_valid_d ? rd_mux : rd_value_q;
    err_d      = req_valid & bad;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      offset_q   <= '0;
      gp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_value_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      offset_q   <= offset_d;
      gp_q       <= gp_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_value_q <= rd_value_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end
  assign ofs_en   = ctrl_q[CTRL_OFS_EN];
  assign sat_en   = ctrl_q[CTRL_SAT_EN];
  assign offset   = offset_q;
  assign rd_value = rd_value_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
endmodule

// File: rtl/one_bit_full_adder.sv
// one_bit_full_adder: single-bit sum and carry cell for the ripple chains
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/dut_nbit_addr_cfg.sv
// dut_nbit_addr_cfg: 2-stage a+b+c_in adder with optional offset and saturation, plus register bank
module dut_nbit_addr_cfg
  import dut_addr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Data_val,
  input  logic [WIDTH-1:0]  Value_a,
  input  logic [WIDTH-1:0]  Value_b,
  input  logic              c_in,
  input  logic [ADDR_W-1:0] Des_address,
  input  logic [WIDTH-1:0]  Des_value,
  input  logic              Des_req_valid,
  input  logic              Des_wr_rd,
  output logic [WIDTH-1:0]  Sum_result,
  output logic              Sum_carry,
  output logic              Data_ready,
  output logic [WIDTH-1:0]  Des_rd_value,
  output logic              Des_rd_valid,
  output logic              Des_err
);
  logic             v1_q, v1_d, cin1_q, cin1_d, ofs_en1_q, ofs_en1_d, sat_en1_q, sat_en1_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, ofs1_q, ofs1_d, sum_q, sum_d;
  logic             carry_q, carry_d, ready_q, ready_d;
  logic [WIDTH-1:0] addend, s1, s2, offset;
  logic [WIDTH:0]   k1, k2;
  logic             ovf, ofs_en, sat_en;
  addr_regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_regs (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(Des_req_valid),
    .wr_rd    (Des_wr_rd),
    .addr     (Des_address),
    .wdata    (Des_value),
    .ovf_set  (v1_q & ovf),
    .cnt_inc  (v1_q),
    .ofs_en   (ofs_en),
    .sat_en   (sat_en),
    .offset   (offset),
    .rd_value (Des_rd_value),
    .rd_valid (Des_rd_valid),
    .err      (Des_err)
  );
  assign k1[0]  = cin1_q;
  assign k2[0]  = 1'b0;
  assign addend = ofs_en1_q ? ofs1_q : '0;
  assign ovf    = k1[WIDTH] | k2[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_sum
    one_bit_full_adder u_fa (.a(a1_q[i]), .b(b1_q[i]), .ci(k1[i]), .s(s1[i]), .co(k1[i+1]));
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ofs
    one_bit_full_adder u_fa (.a(s1[i]), .b(addend[i]), .ci(k2[i]), .s(s2[i]), .co(k2[i+1]));
  end
  // stage 1 snapshots the config so a write on the capture edge only affects later operands
  always_comb begin
    v1_d      = Data_val;
    a1_d      = Data_val ? Value_a : a1_q;
    b1_d      = Data_val ? Value_b : b1_q;
    cin1_d    = Data_val ? c_in : cin1_q;
    ofs1_d    = Data_val ? offset : ofs1_q;
    ofs_en1_d = Data_val ? ofs_en : ofs_en1_q;
    sat_en1_d = Data_val ? sat_en : sat_en1_q;
    sum_d     = v1_q ? ((sat_en1_q & ovf) ? '1 : s2) : sum_q;
    carry_d   = v1_q ? ovf : carry_q;
    ready_d   = v1_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q      <= 1'b0;
      a1_q      <= '0;
      b1_q      <= '0;
      cin1_q    <= 1'b0;
      ofs1_q    <= '0;
      ofs_en1_q <= 1'b0;
      sat_en1_q <= 1'b0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      b1_q      <= b1_d;
      cin1_q    <= cin1_d;
      ofs1_q    <= ofs1_d;
      ofs_en1_q <= ofs_en1_d;
      sat_en1_q <= sat_en1_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      ready_q   <= ready_d;
    end
  end
  assign Sum_result = sum_q;
  assign Sum_carry  = carry_q;
  assign Data_ready = ready_q;
endmodule

// File: tb/tb_dut_nbit_addr_cfg.sv
// tb_dut_nbit_addr_cfg: directed and randomized checks of the adder and register bank against a behavioural model
module tb_dut_nbit_addr_cfg;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       Data_val = 1'b0, c_in = 1'b0, Des_req_valid = 1'b0, Des_wr_rd = 1'b0;
  logic [7:0] Value_a = '0, Value_b = '0, Des_value = '0;
  logic [2:0] Des_address = '0;
  logic [7:0] Sum_result, Des_rd_value;
  logic       Sum_carry, Data_ready, Des_rd_valid, Des_err;
  int checks = 0, errors = 0;
  logic [7:0] m_ctrl, m_off, m_gp, m_cnt, p_res, exp_sum, exp_rdval;
  bit         m_ovf, p_v, p_ovf, exp_carry, exp_ready, exp_rdv, exp_err;

  dut_nbit_addr_cfg dut (
    .clk(clk), .reset_n(reset_n), .Data_val(Data_val), .Value_a(Value_a), .Value_b(Value_b),
    .c_in(c_in), .Des_address(Des_address), .Des_value(Des_value), .Des_req_valid(Des_req_valid),
    .Des_wr_rd(Des_wr_rd), .Sum_result(Sum_result), .Sum_carry(Sum_carry), .Data_ready(Data_ready),
    .Des_rd_value(Des_rd_value), .Des_rd_valid(Des_rd_valid), .Des_err(Des_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void calc(input logic [7:0] a, b, input bit ci, input logic [7:0] ctrl, off,
                               output logic [7:0] res, output bit ov);
    int t1, t2;
    t1  = int'(a) + int'(b) + int'(ci);
    t2  = (t1 % 256) + (ctrl[0] ? int'(off) : 0);
    ov  = (t1 > 255) || (t2 > 255);
    res = (ctrl[1] && ov) ? 8'hFF : 8'(t2 % 256);
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_off = 0; m_gp = 0; m_cnt = 0; m_ovf = 0;
    p_v = 0; p_res = 0; p_ovf = 0;
    exp_sum = 0; exp_carry = 0; exp_ready = 0; exp_rdval = 0; exp_rdv = 0; exp_err = 0;
  endtask

  // one clock: drive inputs, advance the model across the edge, sample 1 time unit later
  task automatic step(input bit dv, input logic [7:0] a, b, input bit ci,
                      input bit rq, wr, input logic [2:0] ad, input logic [7:0] wv);
    logic [7:0] nres;
    bit nov, prod, prod_ovf, bad;
    int ai;
    Data_val = dv; Value_a = a; Value_b = b; c_in = ci;
    Des_req_valid = rq; Des_wr_rd = wr; Des_address = ad; Des_value = wv;
    ai = int'(ad);
    bad = ai > 4;
    prod = p_v;
    prod_ovf = p_ovf;
    exp_ready = p_v;
    if (p_v) begin exp_sum = p_res; exp_carry = p_ovf; end
    nres = 0; nov = 0;
    if (dv) calc(a, b, ci, m_ctrl, m_off, nres, nov);
    p_v = dv;
    if (dv) begin p_res = nres; p_ovf = nov; end
    exp_err = rq && bad;
    exp_rdv = rq && !wr;
    if (rq && !wr)
      exp_rdval = bad ? 8'h00 : ai == 0 ? m_ctrl : ai == 1 ? m_off : ai == 2 ? m_gp :
                  ai == 3 ? {7'b0, m_ovf} : m_cnt;
    if (rq && wr && !bad) begin
      if (ai == 0) m_ctrl = wv;
      if (ai == 1) m_off = wv;
      if (ai == 2) m_gp = wv;
      if (ai == 3 && wv[0]) m_ovf = 0;
    end
    if (prod && prod_ovf) m_ovf = 1;
    if (rq && wr && ai == 4) m_cnt = 0;
    else if (prod) m_cnt = m_cnt + 8'd1;
    @(posedge clk);
    #1;
    Data_val = 0; Des_req_valid = 0;
  endtask

  task automatic idle();                                    step(0, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic rd(input logic [2:0] ad);                   step(0, 0, 0, 0, 1, 0, ad, 0); endtask
  task automatic wr(input logic [2:0] ad, input logic [7:0] v); step(0, 0, 0, 0, 1, 1, ad, v); endtask
  task automatic op(input logic [7:0] a, b, input bit ci);   step(1, a, b, ci, 0, 0, 0, 0); endtask

  task automatic test_reset();
    checks++;
    if ({Sum_result, Sum_carry, Data_ready, Des_rd_value, Des_rd_valid, Des_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got sum=%h c=%b rdy=%b rdv=%h rdvld=%b err=%b required all 0",
               Sum_result, Sum_carry, Data_ready, Des_rd_value, Des_rd_valid, Des_err);
    end
    for (int i = 0; i < 5; i++) begin
      rd(3'(i));
      checks++;
      if ({Des_rd_valid, Des_rd_value} !== 9'h100) begin
        errors++;
        $display("FAIL reset_reg%0d got valid=%b value=%h required valid=1 value=00", i, Des_rd_valid, Des_rd_value);
      end
    end
  endtask

  task automatic test_basic();
    op(8'h12, 8'h34, 1);
    checks++;
    if (Data_ready !== 1'b0) begin errors++; $display("FAIL basic_early_ready got %b required 0", Data_ready); end
    idle();
    checks++;
    if ({Data_ready, Sum_carry, Sum_result} !== {1'b1, 1'b0, 8'h47}) begin
      errors++;
      $display("FAIL basic_sum got rdy=%b c=%b sum=%h required rdy=1 c=0 sum=47", Data_ready, Sum_carry, Sum_result);
    end
    idle();
    checks++;
    if ({Data_ready, Sum_result} !== {1'b0, 8'h47}) begin
      errors++;
      $display("FAIL basic_hold got rdy=%b sum=%h required rdy=0 sum=47", Data_ready, Sum_result);
    end
  endtask

  task automatic test_offset_sat();
    wr(0, 8'h01); wr(1, 8'h10);
    op(8'hF0, 8'h0F, 0); idle();
    checks++;
    if ({Data_ready, Sum_carry, Sum_result} !== {1'b1, 1'b1, 8'h0F}) begin
      errors++;
      $display("FAIL offset_sum got rdy=%b c=%b sum=%h required rdy=1 c=1 sum=0f", Data_ready, Sum_carry, Sum_result);
    end
    rd(3);
    checks++;
    if (Des_rd_value !== 8'h01) begin errors++; $display("FAIL status_set got %h required 01", Des_rd_value); end
    wr(0, 8'h03);
    op(8'hF0, 8'h0F, 0); idle();
    checks++;
    if ({Sum_carry, Sum_result} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL sat_sum got c=%b sum=%h required c=1 sum=ff", Sum_carry, Sum_result);
    end
    wr(3, 8'h01); rd(3);
    checks++;
    if (Des_rd_value !== 8'h00) begin errors++; $display("FAIL status_w1c got %h required 00", Des_rd_value); end
  endtask

  task automatic test_invalid();
    wr(2, 8'h5A);
    rd(6);
    checks++;
    if ({Des_rd_valid, Des_err, Des_rd_value} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL bad_read got valid=%b err=%b value=%h required valid=1 err=1 value=00", Des_rd_valid, Des_err, Des_rd_value);
    end
    rd(2); idle();
    checks++;
    if ({Des_rd_valid, Des_err, Des_rd_value} !== {1'b0, 1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL read_hold got valid=%b err=%b value=%h required valid=0 err=0 value=5a", Des_rd_valid, Des_err, Des_rd_value);
    end
    wr(7, 8'hAA);
    checks++;
    if (Des_err !== 1'b1) begin errors++; $display("FAIL bad_write_err got %b required 1", Des_err); end
    for (int i = 0; i < 3; i++) begin
      rd(3'(i));
      checks++;
      if (Des_rd_value !== (i == 0 ? 8'h03 : i == 1 ? 8'h10 : 8'h5A)) begin
        errors++;
        $display("FAIL bad_write_reg%0d got %h required %h", i, Des_rd_value, i == 0 ? 8'h03 : i == 1 ? 8'h10 : 8'h5A);
      end
    end
  endtask

  task automatic test_same_cycle();
    wr(0, 8'h01); wr(1, 8'h10);
    step(1, 8'h01, 8'h01, 0, 1, 1, 3'd1, 8'h20);
    op(8'h01, 8'h01, 0);
    checks++;
    if (Sum_result !== 8'h12) begin errors++; $display("FAIL write_race_old got %h required 12", Sum_result); end
    idle();
    checks++;
    if (Sum_result !== 8'h22) begin errors++; $display("FAIL write_race_new got %h required 22", Sum_result); end
  endtask

  task automatic test_collisions();
    wr(0, 8'h00); wr(3, 8'h01);
    op(8'hFF, 8'h01, 0);
    wr(3, 8'h01);
    rd(3);
    checks++;
    if (Des_rd_value !== 8'h01) begin errors++; $display("FAIL ovf_set_wins got %h required 01", Des_rd_value); end
    op(8'h01, 8'h01, 0);
    wr(4, 8'h00);
    rd(4);
    checks++;
    if (Des_rd_value !== 8'h00) begin errors++; $display("FAIL count_clear_wins got %h required 00", Des_rd_value); end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    wr(4, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) op(8'($urandom), 8'($urandom), 1'($urandom)); else idle();
      if (Data_ready) seen++;
      checks++;
      if ({Data_ready, Sum_carry, Sum_result} !== {exp_ready, exp_carry, exp_sum}) begin
        errors++;
        $display("FAIL b2b_cycle%0d got rdy=%b c=%b sum=%h required rdy=%b c=%b sum=%h",
                 i, Data_ready, Sum_carry, Sum_result, exp_ready, exp_carry, exp_sum);
      end
    end
    rd(4);
    checks++;
    if (seen != 4 || Des_rd_value !== 8'd4) begin
      errors++;
      $display("FAIL b2b_count got ready=%0d count=%h required 4 and 04", seen, Des_rd_value);
    end
    op(8'h11, 8'h22, 0); op(8'h33, 8'h44, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({Sum_result, Sum_carry, Data_ready, Des_rd_value, Des_rd_valid, Des_err} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got sum=%h c=%b rdy=%b rdv=%h required all 0", Sum_result, Sum_carry, Data_ready, Des_rd_value);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin idle(); if (Data_ready) seen++; end
    rd(4);
    checks++;
    if (seen != 0 || Des_rd_value !== 8'h00) begin
      errors++;
      $display("FAIL reset_flush got ready=%0d count=%h required 0 and 00", seen, Des_rd_value);
    end
  endtask

  task automatic test_random();
    bit dv, rq, w;
    logic [2:0] ad;
    wr(4, 8'h00); wr(3, 8'h01);
    for (int i = 0; i < 400; i++) begin
      dv = $urandom_range(0, 3) != 0;
      rq = $urandom_range(0, 3) == 0;
      w  = 1'($urandom);
      ad = 3'($urandom);
      if (w && ad == 3'd4) ad = 3'd2;
      step(dv, 8'($urandom), 8'($urandom), 1'($urandom), rq, w, ad, 8'($urandom));
      checks++;
      if ({Data_ready, Sum_carry, Sum_result, Des_rd_valid, Des_err, Des_rd_value} !==
          {exp_ready, exp_carry, exp_sum, exp_rdv, exp_err, exp_rdval}) begin
        errors++;
        $display("FAIL random_cycle%0d got rdy=%b c=%b sum=%h rdvld=%b err=%b rdv=%h required rdy=%b c=%b sum=%h rdvld=%b err=%b rdv=%h",
                 i, Data_ready, Sum_carry, Sum_result, Des_rd_valid, Des_err, Des_rd_value,
                 exp_ready, exp_carry, exp_sum, exp_rdv, exp_err, exp_rdval);
      end
    end
    idle(); idle();
    rd(4);
    checks++;
    if (Des_rd_value !== m_cnt) begin errors++; $display("FAIL random_count got %h required %h", Des_rd_value, m_cnt); end
    rd(3);
    checks++;
    if (Des_rd_value !== {7'b0, m_ovf}) begin errors++; $display("FAIL random_status got %h required %h", Des_rd_value, {7'b0, m_ovf}); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_basic();
    test_offset_sat();
    test_invalid();
    test_same_cycle();
    test_collisions();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
